// File: rtl/game_flow_fsm_if.sv
// Purpose: bundles the keyboard/collision inputs and the game-state outputs of game_flow_fsm.
// Ports: keycode, player_hit (controller inputs); ready/playing/paused/respawning/game_over,
//        lives_left, state_out, new_game (controller outputs). master = environment, slave = FSM.
interface game_flow_fsm_if #(
    parameter int KEY_WIDTH = 8,
    parameter int LIVES_W   = 4
);
    logic [KEY_WIDTH-1:0] keycode;
    logic                 player_hit;
    logic                 ready;
    logic                 playing;
    logic                 paused;
    logic                 respawning;
    logic                 game_over;
    logic [LIVES_W-1:0]   lives_left;
    logic [2:0]           state_out;
    logic                 new_game;

    modport master (
        output keycode, player_hit,
        input  ready, playing, paused, respawning, game_over, lives_left, state_out, new_game
    );

    modport slave (
        input  keycode, player_hit,
        output ready, playing, paused, respawning, game_over, lives_left, state_out, new_game
    );
endinterface

// File: rtl/game_flow_fsm.sv
// Purpose: top-level game-flow controller (title, play, pause, respawn, game over) with lives count.
// Latency: state flags follow the state register (Moore); lives_left/new_game are registered, 1 cycle.
// Backpressure: none; key presses are edge-detected so a held key fires exactly once.
// Ports: Clk, ClearA_LoadB (sync active-high reset), bus (slave side of game_flow_fsm_if).
module game_flow_fsm #(
    parameter int                   KEY_WIDTH        = 8,
    parameter logic [KEY_WIDTH-1:0] START_KEY        = 8'h28,
    parameter logic [KEY_WIDTH-1:0] PAUSE_KEY        = 8'h13,
    parameter int                   NUM_LIVES        = 3,
    parameter int                   LIVES_W          = 4,
    parameter int                   RESPAWN_CYCLES   = 60,
    parameter int                   OVER_HOLD_CYCLES = 120,
    parameter int                   TIMER_W          = 8
) (
    input logic          Clk,
    input logic          ClearA_LoadB,
    game_flow_fsm_if.slave bus
);
    localparam logic [2:0] S_START   = 3'd0;
    localparam logic [2:0] S_PLAY    = 3'd1;
    localparam logic [2:0] S_PAUSE   = 3'd2;
    localparam logic [2:0] S_RESPAWN = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    // Respawn loads N-1 so that the countdown through 0 gives exactly N cycles in RESPAWN.
    localparam logic [TIMER_W-1:0] RESPAWN_LOAD = TIMER_W'(RESPAWN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OVER_LOAD    = TIMER_W'(OVER_HOLD_CYCLES);
    localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(NUM_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE    = LIVES_W'(1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO   = '0;

    logic [2:0]           r_state;
    logic [LIVES_W-1:0]   r_lives;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_new_game;
    logic [KEY_WIDTH-1:0] r_key_prev;

    logic [2:0]           w_state_nxt;
    logic [LIVES_W-1:0]   w_lives_nxt;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic                 w_new_game_nxt;
    logic                 w_start_ev;
    logic                 w_pause_ev;

    assign w_start_ev = (bus.keycode == START_KEY) && (r_key_prev != START_KEY);
    assign w_pause_ev = (bus.keycode == PAUSE_KEY) && (r_key_prev != PAUSE_KEY);

    // State register. key_prev is loaded even during reset so a key held through reset never fires.
    always_ff @(posedge Clk) begin
        r_key_prev <= bus.keycode;
        if (ClearA_LoadB) begin
            r_state    <= S_START;
            r_lives    <= '0;
            r_timer    <= '0;
            r_new_game <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lives    <= w_lives_nxt;
            r_timer    <= w_timer_nxt;
            r_new_game <= w_new_game_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_lives_nxt    = r_lives;
        w_timer_nxt    = r_timer;
        w_new_game_nxt = 1'b0;
        case (r_state)
            S_START: begin
                if (w_start_ev) begin
                    w_state_nxt    = S_PLAY;
                    w_lives_nxt    = LIVES_INIT;
                    w_new_game_nxt = 1'b1;
                end
            end
            S_PLAY: begin
                // A hit outranks a pause press in the same cycle.
                if (bus.player_hit) begin
                    if (r_lives > LIVES_ONE) begin
                        w_lives_nxt = r_lives - LIVES_ONE;
                        w_state_nxt = S_RESPAWN;
                        w_timer_nxt = RESPAWN_LOAD;
                    end else begin
                        w_lives_nxt = '0;
                        w_state_nxt = S_OVER;
                        w_timer_nxt = OVER_LOAD;
                    end
                end else if (w_pause_ev) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_pause_ev) begin
                    w_state_nxt = S_PLAY;
                end
            end
            S_RESPAWN: begin
                if (r_timer == TIMER_ZERO) begin
                    w_state_nxt = S_PLAY;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            S_OVER: begin
                if (r_timer != TIMER_ZERO) begin
                    w_timer_nxt = r_timer - 1'b1;
                end else if (w_start_ev) begin
                    w_state_nxt = S_START;
                end
            end
            default: begin
                w_state_nxt = S_START;
            end
        endcase
    end

    // Output decode (Moore flags straight from the state register)
    always_comb begin
        bus.ready      = 1'b0;
        bus.playing    = 1'b0;
        bus.paused     = 1'b0;
        bus.respawning = 1'b0;
        bus.game_over  = 1'b0;
        case (r_state)
            S_START:   bus.ready      = 1'b1;
            S_PLAY:    bus.playing    = 1'b1;
            S_PAUSE:   bus.paused     = 1'b1;
            S_RESPAWN: bus.respawning = 1'b1;
            S_OVER:    bus.game_over  = 1'b1;
            default:   bus.ready      = 1'b0;
        endcase
        bus.state_out  = r_state;
        bus.lives_left = r_lives;
        bus.new_game   = r_new_game;
    end
endmodule
